// File: rtl/sr_cmd_pkg.sv
// Shared types and width helpers for the SR command debouncer.
package sr_cmd_pkg;

  // Arbitration FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Channel select values used when launching a pulse.
  localparam logic SEL_S = 1'b0;
  localparam logic SEL_R = 1'b1;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Debounce counter width.
  function automatic int debounce_width(input int debounce_cycles);
    return cnt_width(debounce_cycles);
  endfunction

  // Hold-off counter width.
  function automatic int holdoff_width(input int holdoff_cycles);
    return cnt_width(holdoff_cycles);
  endfunction

endpackage

// File: rtl/sr_debounce_ch.sv
// One button channel: multi-flop synchronizer, debounce counter and a
// registered one-cycle event on an accepted 0->1 transition.
module sr_debounce_ch
  import sr_cmd_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise_evt
);

  localparam int DW = debounce_width(DEBOUNCE_CYCLES);
  // The level is accepted on the cycle the counter would reach
  // DEBOUNCE_CYCLES, so the compare is against one less.
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [DW-1:0]          cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift the raw button through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Count consecutive disagreeing cycles; accept the new level and flag rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= 1'b0;
      cnt      <= '0;
      rise_evt <= 1'b0;
    end else begin
      rise_evt <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        stable   <= synced;
        cnt      <= '0;
        rise_evt <= synced;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_cmd_debouncer.sv
// Turns two bouncy push buttons into clean, mutually exclusive one-cycle
// s/r pulses with a forced idle gap after each pulse.
module sr_cmd_debouncer
  import sr_cmd_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  localparam int HW = holdoff_width(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          pend_s;
  logic          pend_r;
  logic          evt_s;
  logic          evt_r;
  logic          any_s;
  logic          any_r;
  logic          launch_sel;

  sr_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_ch (
    .clk     (clk),
    .reset   (reset),
    .btn     (set_btn),
    .rise_evt(evt_s)
  );

  sr_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst_ch (
    .clk     (clk),
    .reset   (reset),
    .btn     (rst_btn),
    .rise_evt(evt_r)
  );

  // Requests seen this cycle: queued ones plus fresh events. Pending flags
  // are always clear in IDLE, so there these reduce to the raw events.
  assign any_s = pend_s | evt_s;
  assign any_r = pend_r | evt_r;

  // Channel to pulse when exactly one request is present.
  always_comb begin
    launch_sel = SEL_R;
    if (any_s) launch_sel = SEL_S;
  end

  assign busy = (state != IDLE);

  // Arbitration FSM with hold-off counter, pending flags and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pend_s   <= 1'b0;
      pend_r   <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (any_s && any_r) begin
            conflict <= 1'b1;
          end else if (any_s || any_r) begin
            state <= PULSE;
            s     <= (launch_sel == SEL_S);
            r     <= (launch_sel == SEL_R);
          end
        end
        PULSE: begin
          // Events arriving during the pulse are queued like HOLD events.
          state    <= HOLD;
          hold_cnt <= HOLD_LOAD;
          pend_s   <= any_s;
          pend_r   <= any_r;
        end
        HOLD: begin
          if (hold_cnt <= HOLD_LAST) begin
            hold_cnt <= '0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            if (any_s && any_r) begin
              conflict <= 1'b1;
              state    <= IDLE;
            end else if (any_s || any_r) begin
              state <= PULSE;
              s     <= (launch_sel == SEL_S);
              r     <= (launch_sel == SEL_R);
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
            pend_s   <= any_s;
            pend_r   <= any_r;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Bench for sr_cmd_debouncer: table of button waveforms with expected
// per-cycle outputs, plus hand sequences for reset corners and bounce.
module tb_sr_cmd_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic s, r, conflict, busy;

  int errors = 0;
  int checks = 0;

  // Expected {s, r, conflict, busy} per cycle.
  logic [3:0] exp_q[$];

  typedef struct {
    string       name;
    logic [63:0] set_m;
    logic [63:0] rst_m;
    logic [63:0] s_m;
    logic [63:0] r_m;
    logic [63:0] c_m;
    logic [63:0] b_m;
    int          ncyc;
  } vec_t;

  vec_t vecs[8];

  // Clock and DUT.
  always #5 clk = ~clk;

  sr_cmd_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set_btn (set_btn),
    .rst_btn (rst_btn),
    .s       (s),
    .r       (r),
    .conflict(conflict),
    .busy    (busy)
  );

  // Bit mask with bits [on, on+len) set; bit k means "edge k".
  function automatic logic [63:0] win(input int on, input int len);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) if (i >= on && i < on + len) m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input string name, input logic [63:0] set_m,
                              input logic [63:0] rst_m, input logic [63:0] s_m,
                              input logic [63:0] r_m, input logic [63:0] c_m,
                              input logic [63:0] b_m, input int ncyc);
    vec_t v;
    v.name = name; v.set_m = set_m; v.rst_m = rst_m; v.s_m = s_m;
    v.r_m = r_m; v.c_m = c_m; v.b_m = b_m; v.ncyc = ncyc;
    return v;
  endfunction

  // Drive one cycle at the falling edge, score just after the rising edge.
  task automatic drive_cycle(input string tag, input int cyc, input logic rs,
                             input logic sb, input logic rb, input logic care,
                             input logic [3:0] exp);
    logic [3:0] got;
    logic [3:0] want;
    @(negedge clk);
    reset   = rs;
    set_btn = sb;
    rst_btn = rb;
    if (care) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got = {s, r, conflict, busy};
    checks++;
    if ((s && r) || (conflict && (s || r))) begin
      errors++;
      $display("FAIL invariant %s cyc %0d: got srcb=%b, s/r/conflict must be exclusive", tag, cyc, got);
    end
    if (care) begin
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cyc %0d: got srcb=%b expected srcb=%b", tag, cyc, got, want);
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 1; i <= 2; i++) drive_cycle("reset_state", i, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
  endtask

  task automatic play(input vec_t v);
    for (int k = 1; k <= v.ncyc; k++)
      drive_cycle(v.name, k, 1'b0, v.set_m[k], v.rst_m[k], 1'b1,
                  {v.s_m[k], v.r_m[k], v.c_m[k], v.b_m[k]});
  endtask

  initial begin
    int rem_s, rem_r;
    logic lvl_s, lvl_r;

    vecs[0] = mk("set_hold",    win(1, 40), '0, win(7, 1), '0, '0, win(7, 9), 30);
    vecs[1] = mk("set_glitch3", win(1, 3),  '0, '0, '0, '0, '0, 20);
    vecs[2] = mk("set_min4",    win(1, 4),  '0, win(7, 1), '0, '0, win(7, 9), 20);
    vecs[3] = mk("both_same",   win(1, 40), win(1, 40), '0, '0, win(7, 1), '0, 20);
    vecs[4] = mk("rst_only",    '0, win(1, 10), '0, win(7, 1), '0, win(7, 9), 20);
    vecs[5] = mk("rst_in_hold", win(1, 40), win(10, 30), win(7, 1), win(16, 1), '0, win(7, 18), 30);
    vecs[6] = mk("rst_in_pulse", win(1, 40), win(2, 38), win(7, 1), win(16, 1), '0, win(7, 18), 30);
    vecs[7] = mk("both_pend",   win(1, 4) | win(9, 30), win(2, 38), win(7, 1), '0, win(16, 1), win(7, 9), 30);

    // Reset held with both buttons high, then a held set button pulses at edge 7.
    for (int i = 1; i <= 5; i++) drive_cycle("reset_held", i, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    play(mk("after_reset", win(1, 40), '0, win(7, 1), '0, '0, win(7, 9), 20));

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_reset();
      play(vecs[i]);
    end

    // Reset during PULSE while an r request is arriving aborts everything.
    do_reset();
    for (int k = 1; k <= 7; k++)
      drive_cycle("abort_pulse", k, 1'b0, 1'b1, (k >= 2), 1'b1, (k == 7) ? 4'b1001 : 4'b0000);
    drive_cycle("abort_pulse", 8, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    for (int k = 9; k <= 35; k++)
      drive_cycle("abort_pulse", k, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

    // Bounce with runs of 1-3 cycles never settles long enough to be accepted.
    do_reset();
    lvl_s = 1'b0; lvl_r = 1'b0;
    rem_s = $urandom_range(1, 3); rem_r = $urandom_range(1, 3);
    for (int k = 1; k <= 200; k++) begin
      drive_cycle("short_bounce", k, 1'b0, lvl_s, lvl_r, 1'b1, 4'b0000);
      if (--rem_s == 0) begin lvl_s = ~lvl_s; rem_s = $urandom_range(1, 3); end
      if (--rem_r == 0) begin lvl_r = ~lvl_r; rem_r = $urandom_range(1, 3); end
    end

    // Longer random runs: only the exclusivity invariant is checked.
    for (int k = 1; k <= 400; k++) begin
      drive_cycle("long_bounce", k, 1'b0, lvl_s, lvl_r, 1'b0, 4'b0000);
      if (--rem_s == 0) begin lvl_s = ~lvl_s; rem_s = $urandom_range(1, 10); end
      if (--rem_r == 0) begin lvl_r = ~lvl_r; rem_r = $urandom_range(1, 10); end
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
